// File: rtl/led_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : led_ctrl_pkg
//  Description : Shared constants and state encoding for the front-panel LED
//                page scheduler.
//  Revision    : 1.0 - initial release
// ============================================================================
package led_ctrl_pkg;

    localparam int N_LEDS = 16;

    // Default timing at the 40.079 MHz LHC-derived clock
    localparam int DEFAULT_DWELL_CYCLES = 40079000;  // 1 s per page
    localparam int DEFAULT_GAP_CYCLES   = 4007900;   // 100 ms blank gap

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } sched_state_t;

endpackage : led_ctrl_pkg
`default_nettype wire

// File: rtl/led_page_scheduler_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin search. Scans the request vector
//                starting at 'start' (or start+1 when skip_start is set, in
//                which case 'start' itself is considered last) with wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] start,
    input  logic          skip_start,
    output logic [PW-1:0] winner,
    output logic          found
);

    logic [PW-1:0] idx;

    // First set request in rotated order wins
    always_comb begin
        found  = 1'b0;
        winner = start;
        idx    = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(start) + int'(skip_start) + k) % N);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/led_page_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : led_page_scheduler
//  Description : Time-shares the front-panel LEDs between display pages.
//                Urgent pages preempt immediately; other requesters rotate
//                round-robin with a fixed dwell and a blank gap in between.
//  Revision    : 1.0 - initial release
// ============================================================================
module led_page_scheduler
    import led_ctrl_pkg::*;
#(
    parameter int                 N_PAGES      = 4,
    parameter int                 DWELL_CYCLES = DEFAULT_DWELL_CYCLES,
    parameter int                 GAP_CYCLES   = DEFAULT_GAP_CYCLES,
    parameter logic [N_PAGES-1:0] URGENT_MASK  = {{(N_PAGES-1){1'b0}}, 1'b1}
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [N_PAGES-1:0]            page_req_i,
    input  logic [N_LEDS*N_PAGES-1:0]     page_data_i,
    input  logic                          hold_i,
    output logic [N_LEDS-1:0]             led_o,
    output logic [$clog2(N_PAGES)-1:0]    page_o,
    output logic                          gap_o,
    output logic                          switch_o
);

    localparam int PW   = $clog2(N_PAGES);
    localparam int MAXC = (DWELL_CYCLES > GAP_CYCLES) ? DWELL_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    sched_state_t        state, state_n;
    logic [CW-1:0]       cnt, cnt_n;
    logic [PW-1:0]       rr_ptr, rr_n;
    logic [PW-1:0]       page_n;
    logic                sw_n;
    logic [N_LEDS-1:0]   led_n;

    logic [N_PAGES-1:0]  urg_req;
    logic                urg_any;
    logic [PW-1:0]       urg_idx;
    logic                others;
    logic                leave;
    logic [PW-1:0]       pick_idx;
    logic                pick_found;

    assign urg_req = page_req_i & URGENT_MASK;
    assign urg_any = |urg_req;

    // Lowest-index urgent requester
    always_comb begin
        urg_idx = '0;
        for (int i = N_PAGES - 1; i >= 0; i--) begin
            if (urg_req[i]) begin
                urg_idx = PW'(i);
            end
        end
    end

    // Any requester other than the page currently on display
    always_comb begin
        others = 1'b0;
        for (int i = 0; i < N_PAGES; i++) begin
            if (page_req_i[i] && (PW'(i) != page_o)) begin
                others = 1'b1;
            end
        end
    end

    // IDLE searches from rr_ptr; SHOW/GAP hand-offs search from rr_ptr+1
    rr_pick #(
        .N  (N_PAGES),
        .PW (PW)
    ) u_rr_pick (
        .req        (page_req_i),
        .start      (rr_ptr),
        .skip_start (state != ST_IDLE),
        .winner     (pick_idx),
        .found      (pick_found)
    );

    // Next-state, counter, pointer and pulse decisions
    always_comb begin
        state_n = state;
        page_n  = page_o;
        cnt_n   = cnt;
        rr_n    = rr_ptr;
        sw_n    = 1'b0;
        leave   = 1'b0;

        if (urg_any) begin
            // Urgent page holds the display; counter stalls while it is active
            if ((state != ST_SHOW) || (page_o != urg_idx)) begin
                state_n = ST_SHOW;
                page_n  = urg_idx;
                rr_n    = urg_idx;
                cnt_n   = '0;
                sw_n    = 1'b1;
            end
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (pick_found) begin
                        state_n = ST_SHOW;
                        page_n  = pick_idx;
                        rr_n    = pick_idx;
                        cnt_n   = '0;
                        sw_n    = 1'b1;
                    end
                end
                ST_SHOW: begin
                    // A just-released urgent page also lands here: its request is low
                    if (!page_req_i[page_o]) begin
                        if (others) begin
                            leave = 1'b1;
                        end else begin
                            state_n = ST_IDLE;
                            cnt_n   = '0;
                        end
                    end else if (!hold_i) begin
                        if (cnt == DWELL_LAST) begin
                            if (others) begin
                                leave = 1'b1;
                            end else begin
                                cnt_n = '0;
                            end
                        end else begin
                            cnt_n = cnt + 1'b1;
                        end
                    end
                    if (leave) begin
                        if (GAP_CYCLES == 0) begin
                            state_n = ST_SHOW;
                            page_n  = pick_idx;
                            rr_n    = pick_idx;
                            cnt_n   = '0;
                            sw_n    = 1'b1;
                        end else begin
                            state_n = ST_GAP;
                            cnt_n   = '0;
                        end
                    end
                end
                ST_GAP: begin
                    if (!pick_found) begin
                        state_n = ST_IDLE;
                        cnt_n   = '0;
                    end else if (cnt == GAP_LAST) begin
                        state_n = ST_SHOW;
                        page_n  = pick_idx;
                        rr_n    = pick_idx;
                        cnt_n   = '0;
                        sw_n    = 1'b1;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // Live page data follows the page that will be shown after this edge
    always_comb begin
        led_n = '0;
        if (state_n == ST_SHOW) begin
            led_n = page_data_i[int'(page_n) * N_LEDS +: N_LEDS];
        end
    end

    // State and registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            rr_ptr   <= '0;
            page_o   <= '0;
            led_o    <= '0;
            gap_o    <= 1'b0;
            switch_o <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            rr_ptr   <= rr_n;
            page_o   <= page_n;
            led_o    <= led_n;
            gap_o    <= (state_n == ST_GAP);
            switch_o <= sw_n;
        end
    end

endmodule : led_page_scheduler
`default_nettype wire
